// File: rtl/hitbox_pkg.sv
// Shared definitions for the hitbox scanner and the sprite/projectile logic
// that feeds it, so every block agrees on coordinate width and scan states.
//   COORD_W_DEF  : default coordinate/size width in pixels
//   IFRAMES_DEF  : default invulnerability window in frames after a hit
//   coord_t      : one screen coordinate at the default width
//   scan_state_t : scanner FSM states
package hitbox_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int IFRAMES_DEF = 30;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } scan_state_t;

endpackage

// File: rtl/rect_contact.sv
// Combinational point-in-rectangle test for one object point.
//   active  : channel enable; an inactive point never makes contact
//   px, py  : object point
//   tx, ty  : rectangle top-left corner
//   tw, th  : rectangle width / height (0 means the rectangle is empty)
//   contact : point lies inside [tx, tx+tw) x [ty, ty+th)
module rect_contact #(
  parameter int COORD_W = 10
) (
  input  logic               active,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] tx,
  input  logic [COORD_W-1:0] ty,
  input  logic [COORD_W-1:0] tw,
  input  logic [COORD_W-1:0] th,
  output logic               contact
);

  // One extra bit on the far edges so a rectangle touching the right or
  // bottom of the coordinate space does not wrap around to small values.
  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;

  assign x_end = {1'b0, tx} + {1'b0, tw};
  assign y_end = {1'b0, ty} + {1'b0, th};

  // A zero width or height makes the lower and upper bounds exclusive of
  // each other, so no separate empty-rectangle test is needed.
  assign contact = active
                && (px >= tx) && ({1'b0, px} < x_end)
                && (py >= ty) && ({1'b0, py} < y_end);

endmodule

// File: rtl/hitbox_scanner.sv
// Frame-synchronous hit detection for one fighter. On each rising edge of
// frame_clk the N_OBJ object points are tested one per cycle against a single
// target rectangle; the result is reported as a one-cycle event, gated by an
// invulnerability window that opens after every registered hit.
//   Clk, Reset     : system clock, synchronous active-high reset
//   frame_clk      : frame tick, synchronous to Clk
//   obj_x, obj_y   : packed object coordinates, channel i at [i*COORD_W +: COORD_W]
//   obj_active     : per-channel enable
//   target_*       : target rectangle, captured when a scan starts
//   contact_mask   : raw contacts of the last completed scan
//   hit_valid      : one-cycle pulse when a scan completes
//   hit_mask       : contacts that count as hits (empty while invulnerable)
//   hit_count      : popcount of hit_mask
//   invuln         : invulnerability window open
//   overrun        : sticky, a frame edge arrived while a scan was busy
module hitbox_scanner
  import hitbox_pkg::*;
#(
  parameter int N_OBJ   = 4,
  parameter int COORD_W = COORD_W_DEF,
  parameter int IFRAMES = IFRAMES_DEF,
  parameter int CNT_W   = $clog2(N_OBJ + 1)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_clk,
  input  logic [N_OBJ*COORD_W-1:0]   obj_x,
  input  logic [N_OBJ*COORD_W-1:0]   obj_y,
  input  logic [N_OBJ-1:0]           obj_active,
  input  logic [COORD_W-1:0]         target_x,
  input  logic [COORD_W-1:0]         target_y,
  input  logic [COORD_W-1:0]         target_w,
  input  logic [COORD_W-1:0]         target_h,
  output logic [N_OBJ-1:0]           contact_mask,
  output logic                       hit_valid,
  output logic [N_OBJ-1:0]           hit_mask,
  output logic [CNT_W-1:0]           hit_count,
  output logic                       invuln,
  output logic                       overrun
);

  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int IF_W  = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;

  scan_state_t        state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [N_OBJ-1:0]   work_mask_reg, work_mask_next;
  logic               fc_q_reg;
  logic               frame_edge;

  logic [COORD_W-1:0] tx_reg, ty_reg, tw_reg, th_reg;

  logic [N_OBJ-1:0]   contact_mask_reg;
  logic [N_OBJ-1:0]   hit_mask_reg;
  logic [CNT_W-1:0]   hit_count_reg;
  logic               hit_valid_reg;
  logic               invuln_reg;
  logic               overrun_reg;
  logic [IF_W-1:0]    iframe_cnt_reg, iframe_cnt_next;

  logic               capture;
  logic               commit;
  logic [N_OBJ-1:0]   hit_mask_calc;
  logic [CNT_W-1:0]   hit_count_calc;

  // Unpack the channel buses so the shared checker can be fed by index.
  logic [COORD_W-1:0] obj_x_arr [N_OBJ];
  logic [COORD_W-1:0] obj_y_arr [N_OBJ];

  generate
    for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_unpack
      assign obj_x_arr[gi] = obj_x[gi*COORD_W +: COORD_W];
      assign obj_y_arr[gi] = obj_y[gi*COORD_W +: COORD_W];
    end
  endgenerate

  logic cur_contact;

  rect_contact #(
    .COORD_W (COORD_W)
  ) u_rect_contact (
    .active  (obj_active[idx_reg]),
    .px      (obj_x_arr[idx_reg]),
    .py      (obj_y_arr[idx_reg]),
    .tx      (tx_reg),
    .ty      (ty_reg),
    .tw      (tw_reg),
    .th      (th_reg),
    .contact (cur_contact)
  );

  assign frame_edge = frame_clk & ~fc_q_reg;

  // Next-state logic. The report registers are loaded on the edge that
  // enters REPORT (commit), so they are already valid during the REPORT
  // cycle alongside the hit_valid pulse.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    work_mask_next = work_mask_reg;
    capture        = 1'b0;
    commit         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_edge) begin
          state_next     = SCAN;
          idx_next       = '0;
          work_mask_next = '0;
          capture        = 1'b1;
        end
      end
      SCAN: begin
        work_mask_next = work_mask_reg | (N_OBJ'(cur_contact) << idx_reg);
        if (idx_reg == IDX_W'(N_OBJ - 1)) begin
          state_next = REPORT;
          commit     = 1'b1;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
      REPORT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Hit gating, popcount and the invulnerability counter.
  always_comb begin
    hit_mask_calc   = (iframe_cnt_reg == '0) ? work_mask_next : '0;
    hit_count_calc  = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      hit_count_calc = hit_count_calc + CNT_W'(hit_mask_calc[i]);
    end

    iframe_cnt_next = iframe_cnt_reg;
    if (commit && (iframe_cnt_reg == '0) && (|work_mask_next) && (IFRAMES > 0)) begin
      iframe_cnt_next = IF_W'(IFRAMES);
    end else if (frame_edge && (iframe_cnt_reg != '0)) begin
      iframe_cnt_next = iframe_cnt_reg - IF_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      work_mask_reg    <= '0;
      fc_q_reg         <= 1'b0;
      tx_reg           <= '0;
      ty_reg           <= '0;
      tw_reg           <= '0;
      th_reg           <= '0;
      contact_mask_reg <= '0;
      hit_mask_reg     <= '0;
      hit_count_reg    <= '0;
      hit_valid_reg    <= 1'b0;
      invuln_reg       <= 1'b0;
      overrun_reg      <= 1'b0;
      iframe_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      work_mask_reg  <= work_mask_next;
      fc_q_reg       <= frame_clk;
      hit_valid_reg  <= commit;
      iframe_cnt_reg <= iframe_cnt_next;
      invuln_reg     <= (iframe_cnt_next != '0);
      if (capture) begin
        tx_reg <= target_x;
        ty_reg <= target_y;
        tw_reg <= target_w;
        th_reg <= target_h;
      end
      if (commit) begin
        contact_mask_reg <= work_mask_next;
        hit_mask_reg     <= hit_mask_calc;
        hit_count_reg    <= hit_count_calc;
      end
      // Edges during a busy scan are dropped, only flagged.
      if (frame_edge && (state_reg != IDLE)) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign contact_mask = contact_mask_reg;
  assign hit_valid    = hit_valid_reg;
  assign hit_mask     = hit_mask_reg;
  assign hit_count    = hit_count_reg;
  assign invuln       = invuln_reg;
  assign overrun      = overrun_reg;

endmodule
